// File: rtl/adder_pkg.sv
// adder_pkg: sizing helpers shared by the pipelined carry-select adder.
// Block count, stage count and stage-to-block mapping.
package adder_pkg;

  function automatic int ceil_div(input int n, input int d);
    return (d < 1) ? 1 : (n + d - 1) / d;
  endfunction

  function automatic int nblk(input int w, input int bw);
    return (bw < 1) ? 1 : w / bw;
  endfunction

  function automatic int nstages(input int w, input int bw, input int bps);
    return ceil_div(nblk(w, bw), bps);
  endfunction

  function automatic int last_blk(input int k, input int bps, input int n);
    return (((k + 1) * bps < n) ? (k + 1) * bps : n) - 1;
  endfunction

endpackage

// File: rtl/MUX2to1_wN.sv
// MUX2to1_wN: N-bit two-input multiplexer.
// sel=0 picks d0, sel=1 picks d1.
module MUX2to1_wN #(
  parameter int N = 1
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic         sel,
  output logic [N-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/csa_block.sv
// csa_block: one carry-select block; both carry-in outcomes are
// precomputed and the true incoming carry picks sum and carry.
module csa_block
  import adder_pkg::*;
#(
  parameter int BLOCK_WIDTH = 4
) (
  input  logic [BLOCK_WIDTH-1:0] a,
  input  logic [BLOCK_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [BLOCK_WIDTH-1:0] sum,
  output logic                   cout
);

  logic [BLOCK_WIDTH-1:0] sum0;
  logic [BLOCK_WIDTH-1:0] sum1;
  logic                   cout0;
  logic                   cout1;

  ripple_carry_adder #(.W(BLOCK_WIDTH)) u_rca0 (
    .a    (a),
    .b    (b),
    .cin  (1'b0),
    .sum  (sum0),
    .cout (cout0)
  );

  ripple_carry_adder #(.W(BLOCK_WIDTH)) u_rca1 (
    .a    (a),
    .b    (b),
    .cin  (1'b1),
    .sum  (sum1),
    .cout (cout1)
  );

  MUX2to1_wN #(.N(BLOCK_WIDTH)) u_sum_mux (
    .d0  (sum0),
    .d1  (sum1),
    .sel (cin),
    .y   (sum)
  );

  MUX2to1_wN #(.N(1)) u_cout_mux (
    .d0  (cout0),
    .d1  (cout1),
    .sel (cin),
    .y   (cout)
  );

endmodule

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: W-bit combinational ripple adder.
// Building block for the carry-select blocks.
module ripple_carry_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[W];

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: valid/ready pipelined carry-select add/sub.
// Define PCSA_OVF_EN to add the signed-overflow output ovf.
module pipelined_carry_select_adder
  import adder_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int BLOCK_WIDTH      = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PCSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BW   = BLOCK_WIDTH;
  localparam int BPS  = (BLOCKS_PER_STAGE < 1) ? 1 : BLOCKS_PER_STAGE;
  localparam int NBLK = nblk(WIDTH, BW);
  localparam int NST  = nstages(WIDTH, BW, BPS);
  localparam int L    = NST - 1;

  if ((WIDTH % BLOCK_WIDTH) != 0 || BLOCKS_PER_STAGE < 1) begin : g_cfg_err
    $error("pcsa: WIDTH must be a multiple of BLOCK_WIDTH, BPS >= 1");
  end

  logic [NST-1:0]   v_q;
  logic [NST-1:0]   v_in;
  logic [NST:0]     rdy;
  logic [WIDTH-1:0] a_q  [NST];
  logic [WIDTH-1:0] b_q  [NST];
  logic [WIDTH-1:0] s_q  [NST];
  logic             c_q  [NST];
  logic [WIDTH-1:0] a_st [NST];
  logic [WIDTH-1:0] b_st [NST];
  logic [WIDTH-1:0] s_st [NST];
  logic [WIDTH-1:0] s_nx [NST];
  logic             c_st [NST];
  logic             c_nx [NST];
  logic [WIDTH-1:0] blk_sum;

  always_comb begin
    rdy      = '0;
    rdy[NST] = out_ready;
    for (int k = NST - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] | rdy[k + 1];
    end
  end

  always_comb begin
    v_in    = '0;
    v_in[0] = in_valid;
    for (int k = 1; k < NST; k++) begin
      v_in[k] = v_q[k - 1];
    end
  end

  // Stage 0 takes the port operands; later stages take the skewed regs.
  for (genvar k = 0; k < NST; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_st[k] = a;
      assign b_st[k] = b ^ {WIDTH{sub}};
      assign s_st[k] = '0;
      assign c_st[k] = sub | cin;
    end else begin : g_next
      assign a_st[k] = a_q[k - 1];
      assign b_st[k] = b_q[k - 1];
      assign s_st[k] = s_q[k - 1];
      assign c_st[k] = c_q[k - 1];
    end
  end

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    localparam int K = i / BPS;
    logic ci;
    logic co;

    if (i % BPS == 0) begin : g_head
      assign ci = c_st[K];
    end else begin : g_link
      assign ci = g_blk[i - 1].co;
    end

    if (i == last_blk(K, BPS, NBLK)) begin : g_tail
      assign c_nx[K] = co;
    end

    csa_block #(.BLOCK_WIDTH(BW)) u_csa (
      .a    (a_st[K][i*BW +: BW]),
      .b    (b_st[K][i*BW +: BW]),
      .cin  (ci),
      .sum  (blk_sum[i*BW +: BW]),
      .cout (co)
    );
  end

  always_comb begin
    for (int k = 0; k < NST; k++) begin
      s_nx[k] = s_st[k];
      for (int j = 0; j < NBLK; j++) begin
        if (j / BPS == k) begin
          s_nx[k][j*BW +: BW] = blk_sum[j*BW +: BW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < NST; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NST; k++) begin
        if (rdy[k]) begin
          v_q[k] <= v_in[k];
          if (v_in[k]) begin
            a_q[k] <= a_st[k];
            b_q[k] <= b_st[k];
            s_q[k] <= s_nx[k];
            c_q[k] <= c_nx[k];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign cout      = c_q[L];

`ifdef PCSA_OVF_EN
  // b_q already holds the effective (possibly inverted) operand.
  assign ovf = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1])
             & (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
`endif

  logic unused_tail;
  assign unused_tail = ^{a_q[L], b_q[L]};

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// tb_pipelined_carry_select_adder: scoreboard bench over three geometries
// at WIDTH=16: BPS=2 (2 stages), BPS=4 (1 stage), BPS=3 (uneven 2 stages).
module tb_pipelined_carry_select_adder;

  localparam int W  = 16;
  localparam int ND = 3;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  function automatic int bps_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 4 : 3;
  endfunction

  function automatic int nst_of(input int d);
    return (d == 1) ? 1 : 2;
  endfunction

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    logic [W-1:0] ye;
    logic [W:0]   t;
    res_t         r;
    ye     = s ? ~y : y;
    t      = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s | c)};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [1:0]   sel = 2'd0;

  logic [ND-1:0] iv;
  logic [ND-1:0] ir;
  logic [ND-1:0] ov;
  logic [ND-1:0] co;
  logic [W-1:0]  sm [ND];
  logic          in_ready_m;
  logic          out_valid_m;
  logic          cout_m;
  logic [W-1:0]  sum_m;
`ifdef PCSA_OVF_EN
  logic [ND-1:0] of;
  logic          ovf_m;
`endif

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_out = 0;
  int   n_flush = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int d = 0; d < ND; d++) iv[d] = in_valid && (int'(sel) == d);
    in_ready_m  = ir[sel];
    out_valid_m = ov[sel];
    cout_m      = co[sel];
    sum_m       = sm[sel];
  end
`ifdef PCSA_OVF_EN
  assign ovf_m = of[sel];
`endif

  for (genvar d = 0; d < ND; d++) begin : g_dut
    pipelined_carry_select_adder #(
      .WIDTH            (W),
      .BLOCK_WIDTH      (4),
      .BLOCKS_PER_STAGE (bps_of(d))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[d]),
      .in_ready  (ir[d]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (ov[d]),
      .out_ready (out_ready),
      .sum       (sm[d]),
      .cout      (co[d])
`ifdef PCSA_OVF_EN
      ,
      .ovf       (of[d])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      n_flush += sb.size();
      sb.delete();
    end else begin
      if (out_valid_m && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          n_out++;
          check("sb_sum", sum_m, e.sum);
          check("sb_cout", cout_m, e.cout);
`ifdef PCSA_OVF_EN
          check("sb_ovf", ovf_m, e.ovf);
`endif
        end
      end
      if (in_valid && in_ready_m) begin
        sb.push_back(model(a, b, cin, sub));
        n_acc++;
      end
    end
  end

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts);
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready_m) break;
    end
    if (!in_ready_m) check("in_timeout", in_ready_m, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic new_beat();
    a = W'($urandom); b = W'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid_m && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    check("out_seen", out_valid_m, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid_m) && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic one(input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic tc, input logic ts, input logic [W-1:0] es,
                     input logic ec, input logic eo, input string tag);
    int lat;
    drive(ta, tb, tc, ts);
    wait_out(lat);
    check({tag, "_lat"}, lat + 1, nst_of(int'(sel)));
    check({tag, "_sum"}, sum_m, es);
    check({tag, "_cout"}, cout_m, ec);
`ifdef PCSA_OVF_EN
    check({tag, "_ovf"}, ovf_m, eo);
`else
    if (eo) check({tag, "_ovf_model"}, model(ta, tb, tc, ts).ovf, eo);
`endif
    drain();
  endtask

  task automatic stall_test();
    logic [W-1:0] hs;
    int           acc0;
    logic         took;
    acc0 = n_acc;
    out_ready = 1'b0;
    new_beat();
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      took = in_ready_m;
      @(posedge clk);
      #1;
      if (took) new_beat();
    end
    @(negedge clk);
    #1;
    check("stall_in_ready", in_ready_m, 0);
    check("stall_accepted", n_acc - acc0, nst_of(int'(sel)));
    check("stall_out_valid", out_valid_m, 1);
    hs = sum_m;
    repeat (2) begin
      @(negedge clk);
      check("stall_hold", sum_m, hs);
    end
    out_ready = 1'b1;
    drive(a, b, cin, sub);
    repeat (3) begin
      new_beat();
      drive(a, b, cin, sub);
    end
  endtask

  initial begin
    int t0;
    int nb;
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check("rst_out_valid", ov[d], 0);
      check("rst_sum", sm[d], 0);
      check("rst_cout", co[d], 0);
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int d = 0; d < ND; d++) begin
      sel = 2'(d);
      one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_wrap");
      one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
      one(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_noborrow");
      nb = (d == 0) ? 1000 : 200;
      t0 = cyc;
      for (int i = 0; i < nb; i++) begin
        new_beat();
        drive(a, b, cin, sub);
      end
      check("throughput", cyc - t0, nb);
      drain();
      stall_test();
      drain();
    end

    sel = 2'd0;
    out_ready = 1'b1;
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    drive(16'h3333, 16'h0444, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid_m, 0);
    check("midrst_sum", sum_m, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_m) cnt++;
    end
    check("midrst_no_ghost", cnt, 0);
    check("midrst_flushed", n_flush, 2);
    @(posedge clk);
    #1;
    one(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, "post_rst");

    one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_neg");
    one(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, "ovf_none");

    check("beat_count", n_out, n_acc - n_flush);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
